eacs_213: RTL and testbench
===========================

# eacs_213

Add-compare-select unit for the efficient (2,1,3) backward-label Viterbi decoder. It sits directly upstream of the metric-updating/control unit.

- On the control unit's load strobe it captures a received 2-bit code symbol and forms four Hamming branch metrics.
- On the add strobe it adds those metrics to the current 8 partial path metrics, picks one survivor per state and produces:
  - 8 updated metrics, which feed the control unit's metric inputs;
  - 8 one-bit decisions, which feed its path-memory inputs.

## Interface
Parameters (from the shared params include):
- `W`, 4: path metric width; saturating ceiling is 2^W-1 = 15.
- `n`, 2: code symbol width.
- `k`, 1: decision width.
- `NORM`, 8: normalisation subtrahend. Must equal 2^(W-1).

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `le`  in  1: load strobe from control; capture `rx` and branch metrics.
- `ae`  in  1: add strobe from control; perform ACS.
- `rx`  in  `n`: received symbol; rx[1] is c0, rx[0] is c1.
- `A0_old`..`A7_old`  in  `W` each: current partial path metrics (control's A*_out).
- `A0_new`..`A7_new`  out  `W` each: registered survivor metrics (control's A*_in).
- `P0`..`P7`  out  `k` each: registered survivor decisions (control's P*_in).
- `acs_valid`  out  1: one-cycle pulse; new metrics/decisions registered this cycle.
- `norm_evt`  out  1: one-cycle pulse coincident with `acs_valid` when normalisation was applied.

## Operation
Trellis, state s = s[2:0]:
- Predecessors of s: p0 = {0, s[2:1]} and p1 = {1, s[2:1]}.
- Decision bit d is the MSB of the chosen predecessor. This matches the backward-label traceback {P[s], s[2:1]}.
- Input bit u = s[0].
- Branch outputs for predecessor p:
  - c0 = u ^ p[0] ^ p[1] ^ p[2] (g0 = 1111);
  - c1 = u ^ p[0] ^ p[2] (g1 = 1101).

Branch metric:
- BM = popcount(rx ^ {c0, c1}), range 0..2.
- Only four distinct metrics exist, indexed by {c0, c1}. Register BM00, BM01, BM10, BM11, each 2 bits.

Load (le=1 at a rising edge):
- Register `rx`; compute and register BM00..BM11.
- Metric and decision outputs hold.

Add (ae=1 at a rising edge), for each state s:
- Compute m0 = A_old[p0] + BM(p0→s) and m1 = A_old[p1] + BM(p1→s) at W+1 bits.
- Saturate each to 15.
- Select: d = (m1 < m0) ? 1 : 0. Ties pick p0, d = 0.
- Survivor S_s = d ? m1 : m0.

Normalisation:
- If all eight S_s are ≥ NORM, subtract NORM from every survivor before registering, and pulse `norm_evt`.
- Otherwise register the survivors unchanged.
- Register A_new and P; pulse `acs_valid` for exactly one cycle.

Strobe rules:
- le and ae both high in the same cycle: le takes priority. Only the load happens; ACS is skipped and `acs_valid` stays low.
- ae with no prior le since reset uses the reset BMs (all 0).

Reset (asynchronous, immediate):
- A0_new = 0; A1_new..A7_new = 15.
- P0..P7 = 0; BMs = 0; rx register = 0.
- `acs_valid` = 0; `norm_evt` = 0.
- Reset mid-operation discards any pending load or ACS.

## Timing
- Control sequence is LOAD_HD (le) → ADD_HD (ae) → WRITE_METRICS (we).
- BM registers update at the edge ending the le cycle.
- A_new, P and `acs_valid` update at the edge ending the ae cycle. They are therefore stable throughout the we cycle, when control samples them.
- ACS latency is 1 clock from ae sampled to outputs valid. le-to-outputs is 2 clocks.
- Outputs hold until the next ae edge. A_old may change freely outside the ae cycle.
- The ACS critical path (add, compare, 8-wide min-check, subtract) must close in one clock. No pipelining is allowed, because control allows exactly one cycle between ae and we.
- The block has no backpressure; control guarantees at least one cycle between strobes.

## Test plan
1. **Reset values:** assert reset mid-cycle → A0_new=0, A1..A7_new=15, P*=0, acs_valid=0, all immediately with no clock.
2. **First stage from reset metrics:** A_old = {0,15,...,15}, rx=2'b00, le then ae.
   - Required: A0_new=0 (P0=0); A1_new=2 (P1=0).
   - All others saturate to 15, ties select d=0.
   - acs_valid pulses once, 1 cycle after ae.
3. **All-zero codeword:**
   - Stimulus: rx=00 for 10 stages, A_new fed back to A_old.
   - Required: A0_new stays 0; P0 is always 0.
   - No other state is ever below 2; norm_evt never fires.
4. **Tie and saturation:**
   - Stimulus: A_old all 14, rx=01.
   - Required: each per-state min equals min over predecessors, capped at 15; every P where m0==m1 is 0.
5. **Normalisation:**
   - Stimulus: A_old all 9, rx=00.
   - Required: survivors are in 9..11 before normalisation, so each output is survivor−8 (each in 1..3); norm_evt=1 coincident with acs_valid.
   - Then A_old with A3=7: no normalisation, norm_evt=0.
6. **Strobe collision and reset:**
   - Stimulus: le and ae together with rx=11. Required: BMs load, outputs unchanged, no acs_valid.
   - Stimulus: reset asserted between le and ae. Required: the following ae uses zero BMs.

Source files
------------

// File: rtl/eacs_213.sv
// Add-compare-select stage for the (2,1,3) backward-label Viterbi decoder.
// Loads four Hamming branch metrics on le, updates 8 survivor metrics/decisions on ae.
module eacs_213 #(
   parameter int unsigned W    = 4,
   parameter int unsigned n    = 2,
   parameter int unsigned k    = 1,
   parameter int unsigned NORM = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         le,
   input  logic         ae,
   input  logic [n-1:0] rx,
   input  logic [W-1:0] A0_old,
   input  logic [W-1:0] A1_old,
   input  logic [W-1:0] A2_old,
   input  logic [W-1:0] A3_old,
   input  logic [W-1:0] A4_old,
   input  logic [W-1:0] A5_old,
   input  logic [W-1:0] A6_old,
   input  logic [W-1:0] A7_old,
   output logic [W-1:0] A0_new,
   output logic [W-1:0] A1_new,
   output logic [W-1:0] A2_new,
   output logic [W-1:0] A3_new,
   output logic [W-1:0] A4_new,
   output logic [W-1:0] A5_new,
   output logic [W-1:0] A6_new,
   output logic [W-1:0] A7_new,
   output logic [k-1:0] P0,
   output logic [k-1:0] P1,
   output logic [k-1:0] P2,
   output logic [k-1:0] P3,
   output logic [k-1:0] P4,
   output logic [k-1:0] P5,
   output logic [k-1:0] P6,
   output logic [k-1:0] P7,
   output logic         acs_valid,
   output logic         norm_evt
);

   localparam int unsigned NS  = 8;
   localparam int unsigned NBM = 4;

   // {c0, c1} emitted on the branch from predecessor p with input bit u
   function automatic logic [1:0] code_of(input logic [2:0] p, input logic u);
      return {u ^ p[0] ^ p[1] ^ p[2], u ^ p[0] ^ p[2]};
   endfunction

   function automatic logic [1:0] bm_of(input logic [1:0] r, input logic [1:0] c);
      return 2'(r[1] ^ c[1]) + 2'(r[0] ^ c[0]);
   endfunction

   // W+1-bit sum clamped to the W-bit ceiling
   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] b);
      logic [W:0] sum;
      sum = (W+1)'(a) + (W+1)'(b);
      return sum[W] ? {W{1'b1}} : sum[W-1:0];
   endfunction

   logic [n-1:0]  rx_q;
   logic [1:0]    bm_q  [NBM];
   logic [1:0]    bm_c  [NBM];
   logic [W-1:0]  a_old [NS];
   logic [W-1:0]  a_q   [NS];
   logic [W-1:0]  surv  [NS];
   logic [NS-1:0] d_q;
   logic [NS-1:0] dec_c;
   logic [NS-1:0] ge_norm;
   logic          norm_c;

   assign a_old = '{A0_old, A1_old, A2_old, A3_old, A4_old, A5_old, A6_old, A7_old};

   for (genvar gc = 0; gc < NBM; gc++) begin : g_bm
      assign bm_c[gc] = bm_of(rx, 2'(gc));
   end

   // Per-state add/compare/select; p1 differs from p0 only in its MSB
   for (genvar gs = 0; gs < NS; gs++) begin : g_acs
      localparam logic [2:0] ST    = 3'(gs);
      localparam logic [2:0] PR0   = {1'b0, ST[2:1]};
      localparam logic [2:0] PR1   = {1'b1, ST[2:1]};
      localparam logic [1:0] CODE0 = code_of(PR0, ST[0]);
      localparam logic [1:0] CODE1 = code_of(PR1, ST[0]);
      logic [W-1:0] m0;
      logic [W-1:0] m1;
      assign m0          = sat_add(a_old[PR0], bm_q[CODE0]);
      assign m1          = sat_add(a_old[PR1], bm_q[CODE1]);
      assign dec_c[gs]   = (m1 < m0);
      assign surv[gs]    = dec_c[gs] ? m1 : m0;
      assign ge_norm[gs] = (surv[gs] >= W'(NORM));
   end

   assign norm_c = &ge_norm;

   // Load has priority over add; a reset drops whatever was loaded
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_q      <= '0;
         d_q       <= '0;
         acs_valid <= 1'b0;
         norm_evt  <= 1'b0;
         for (int i = 0; i < int'(NBM); i++) bm_q[i] <= '0;
         for (int i = 0; i < int'(NS); i++) a_q[i] <= (i == 0) ? '0 : '1;
      end else begin
         acs_valid <= 1'b0;
         norm_evt  <= 1'b0;
         if (le) begin
            rx_q <= rx;
            for (int i = 0; i < int'(NBM); i++) bm_q[i] <= bm_c[i];
         end else if (ae) begin
            for (int i = 0; i < int'(NS); i++)
               a_q[i] <= norm_c ? (surv[i] - W'(NORM)) : surv[i];
            d_q       <= dec_c;
            acs_valid <= 1'b1;
            norm_evt  <= norm_c;
         end
      end
   end

   // The captured symbol and the metric bank must always agree
   a_bm_track: assert property (@(posedge clock) disable iff (reset)
                                bm_q[0] == bm_of(rx_q, 2'b00));

   assign A0_new = a_q[0];
   assign A1_new = a_q[1];
   assign A2_new = a_q[2];
   assign A3_new = a_q[3];
   assign A4_new = a_q[4];
   assign A5_new = a_q[5];
   assign A6_new = a_q[6];
   assign A7_new = a_q[7];

   assign P0 = k'(d_q[0]);
   assign P1 = k'(d_q[1]);
   assign P2 = k'(d_q[2]);
   assign P3 = k'(d_q[3]);
   assign P4 = k'(d_q[4]);
   assign P5 = k'(d_q[5]);
   assign P6 = k'(d_q[6]);
   assign P7 = k'(d_q[7]);

endmodule

// File: tb/tb_eacs_213.sv
// Directed bench for eacs_213: hand-computed ACS vectors plus strobe/reset sequences.
module tb_eacs_213;

   logic       clock;
   logic       reset;
   logic       le;
   logic       ae;
   logic [1:0] rx_i;
   logic [3:0] a_old [8];
   logic [3:0] a_new [8];
   logic       p_bit [8];
   logic       acs_valid;
   logic       norm_evt;

   int checks = 0;
   int errors = 0;

   // Metrics packed with state 0 in the low nibble
   typedef struct packed {
      logic [1:0]  rx;
      logic [31:0] a_in;
      logic [31:0] exp_a;
      logic [7:0]  exp_p;
      logic        exp_norm;
   } vec_t;

   eacs_213 dut (
      .clock(clock), .reset(reset), .le(le), .ae(ae), .rx(rx_i),
      .A0_old(a_old[0]), .A1_old(a_old[1]), .A2_old(a_old[2]), .A3_old(a_old[3]),
      .A4_old(a_old[4]), .A5_old(a_old[5]), .A6_old(a_old[6]), .A7_old(a_old[7]),
      .A0_new(a_new[0]), .A1_new(a_new[1]), .A2_new(a_new[2]), .A3_new(a_new[3]),
      .A4_new(a_new[4]), .A5_new(a_new[5]), .A6_new(a_new[6]), .A7_new(a_new[7]),
      .P0(p_bit[0]), .P1(p_bit[1]), .P2(p_bit[2]), .P3(p_bit[3]),
      .P4(p_bit[4]), .P5(p_bit[5]), .P6(p_bit[6]), .P7(p_bit[7]),
      .acs_valid(acs_valid), .norm_evt(norm_evt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack_a();
      logic [31:0] r;
      for (int i = 0; i < 8; i++) r[i*4 +: 4] = a_new[i];
      return r;
   endfunction

   function automatic logic [7:0] pack_p();
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = p_bit[i];
      return r;
   endfunction

   task automatic set_a(input logic [31:0] a);
      for (int i = 0; i < 8; i++) a_old[i] = a[i*4 +: 4];
   endtask

   // LOAD then ADD on consecutive cycles; returns in the cycle the results are valid
   task automatic run_acs(input logic [1:0] r, input logic [31:0] a);
      rx_i = r;
      le   = 1'b1;
      tick();
      le   = 1'b0;
      rx_i = 2'b00;
      set_a(a);
      ae   = 1'b1;
      tick();
      ae   = 1'b0;
   endtask

   vec_t vecs [7];

   initial begin
      logic [31:0] a_cur;
      logic [31:0] prev_a;
      logic [7:0]  prev_p;
      logic        ok;

      vecs[0] = '{rx: 2'b00, a_in: 32'hFFFFFFF0, exp_a: 32'hFFFFFF20, exp_p: 8'h00, exp_norm: 1'b0};
      vecs[1] = '{rx: 2'b01, a_in: 32'hEEEEEEEE, exp_a: 32'h66667777, exp_p: 8'h90, exp_norm: 1'b1};
      vecs[2] = '{rx: 2'b00, a_in: 32'h99999999, exp_a: 32'h22221111, exp_p: 8'h06, exp_norm: 1'b1};
      vecs[3] = '{rx: 2'b01, a_in: 32'h99997999, exp_a: 32'h9799AAAA, exp_p: 8'h10, exp_norm: 1'b0};
      vecs[4] = '{rx: 2'b10, a_in: 32'h01234567, exp_a: 32'h20133344, exp_p: 8'hFF, exp_norm: 1'b0};
      vecs[5] = '{rx: 2'b11, a_in: 32'hFFFFFFFF, exp_a: 32'h77777777, exp_p: 8'h00, exp_norm: 1'b1};
      vecs[6] = '{rx: 2'b10, a_in: 32'h76543210, exp_a: 32'h35422211, exp_p: 8'h00, exp_norm: 1'b0};

      reset = 1'b1; le = 1'b0; ae = 1'b0; rx_i = 2'b00;
      set_a(32'h0);
      tick();
      check("rst_a", pack_a(), 32'hFFFFFFF0);
      check("rst_p", 32'(pack_p()), 32'h0);
      check("rst_valid", 32'(acs_valid), 32'h0);
      check("rst_norm", 32'(norm_evt), 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_acs(vecs[i].rx, vecs[i].a_in);
         check($sformatf("v%0d_valid", i), 32'(acs_valid), 32'h1);
         check($sformatf("v%0d_a", i), pack_a(), vecs[i].exp_a);
         check($sformatf("v%0d_p", i), 32'(pack_p()), 32'(vecs[i].exp_p));
         check($sformatf("v%0d_norm", i), 32'(norm_evt), 32'(vecs[i].exp_norm));
         set_a(32'h0);
         tick();
         check($sformatf("v%0d_valid_drop", i), 32'(acs_valid), 32'h0);
         check($sformatf("v%0d_norm_drop", i), 32'(norm_evt), 32'h0);
         check($sformatf("v%0d_hold", i), pack_a(), vecs[i].exp_a);
      end

      // Asynchronous reset in the middle of a cycle, no edge in between
      #3 reset = 1'b1;
      #1;
      check("async_rst_a", pack_a(), 32'hFFFFFFF0);
      check("async_rst_p", 32'(pack_p()), 32'h0);
      check("async_rst_valid", 32'(acs_valid), 32'h0);
      #1 reset = 1'b0;
      tick();

      // All-zero codeword with metrics fed back
      a_cur = 32'hFFFFFFF0;
      for (int s = 0; s < 10; s++) begin
         run_acs(2'b00, a_cur);
         check($sformatf("zc%0d_a0", s), 32'(a_new[0]), 32'h0);
         check($sformatf("zc%0d_p0", s), 32'(p_bit[0]), 32'h0);
         check($sformatf("zc%0d_norm", s), 32'(norm_evt), 32'h0);
         ok = 1'b1;
         for (int j = 1; j < 8; j++) if (a_new[j] < 4'd2) ok = 1'b0;
         check($sformatf("zc%0d_others_ge2", s), 32'(ok), 32'h1);
         a_cur = pack_a();
         tick();
      end

      // le and ae together: only the load happens
      prev_a = pack_a();
      prev_p = pack_p();
      rx_i = 2'b11;
      set_a(32'h0);
      le = 1'b1;
      ae = 1'b1;
      tick();
      le = 1'b0;
      ae = 1'b0;
      check("coll_valid", 32'(acs_valid), 32'h0);
      check("coll_a_hold", pack_a(), prev_a);
      check("coll_p_hold", 32'(pack_p()), 32'(prev_p));
      ae = 1'b1;
      tick();
      ae = 1'b0;
      check("coll_add_valid", 32'(acs_valid), 32'h1);
      check("coll_add_a", pack_a(), 32'h11110000);
      check("coll_add_p", 32'(pack_p()), 32'h09);
      check("coll_add_norm", 32'(norm_evt), 32'h0);
      tick();

      // Reset between le and ae discards the loaded metrics
      rx_i = 2'b11;
      le = 1'b1;
      tick();
      le = 1'b0;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      set_a(32'h0);
      ae = 1'b1;
      tick();
      ae = 1'b0;
      check("rstmid_valid", 32'(acs_valid), 32'h1);
      check("rstmid_a", pack_a(), 32'h0);
      check("rstmid_p", 32'(pack_p()), 32'h0);
      check("rstmid_norm", 32'(norm_evt), 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
